// File: rtl/rv_pkg.sv
// Shared RV32I constants, loader state type and the field-to-word encoder.
// The fetch/decode side reuses the opcode constants from this package.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_WORD = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        TERM,
        DONE
    } loader_state_t;

    typedef struct packed {
        logic        ok;
        logic [31:0] word;
    } enc_result_t;

    // Inverse of the fetch-side field extraction; ok=0 flags an unsupported opcode.
    function automatic enc_result_t rv_encode(
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        enc_result_t r;
        r.ok   = 1'b1;
        r.word = NOP_WORD;
        case (opcode)
            OP_R: begin
                r.word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            OP_I, OP_LOAD: begin
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (opcode == OP_I && (funct3 == 3'b001 || funct3 == 3'b101)) begin
                    r.word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                end else begin
                    r.word = {imm[11:0], rs1, funct3, rd, opcode};
                end
            end
            OP_STORE: begin
                r.word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            OP_BRANCH: begin
                r.word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            end
            default: begin
                r.ok = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO for encoded words; push while full is allowed
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        head = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Encodes decoded instruction bundles into RV32I words, writes them sequentially
// into program RAM and finishes with a NO-OP terminator.
module inst_mem_loader
    import rv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_INST   = 18,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [WIDTH-1:0] imm,
    output logic             mem_wr_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] count
);

    localparam int ACC_W = $clog2(NUM_INST) + 1;

    loader_state_t    state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [ACC_W-1:0] accepted_q, accepted_d;

    enc_result_t      enc;
    logic             accept;
    logic             wr_en;
    logic             wr_fire;
    logic             term_phase;
    logic             in_ready_c;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      fifo_head;

    sync_fifo #(
        .WIDTH      (32),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (enc.word),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Datapath and handshake qualifiers.
    always_comb begin
        enc        = rv_encode(opcode, rd, rs1, rs2, funct3, funct7, 32'(imm));
        // The last RAM slot is always kept for the terminator.
        in_ready_c = (state_q == LOAD) && !fifo_full &&
                     (accepted_q < ACC_W'(NUM_INST - 1));
        accept     = in_valid && in_ready_c;
        term_phase = (state_q == TERM) && fifo_empty;
        wr_en      = (((state_q == LOAD) || (state_q == TERM)) && !fifo_empty) || term_phase;
        wr_fire    = wr_en && mem_ready;
        fifo_push  = accept && enc.ok;
        fifo_pop   = wr_fire && !fifo_empty;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        err_d      = err_q;
        accepted_d = accepted_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    addr_d     = '0;
                    count_d    = '0;
                    err_d      = 1'b0;
                    accepted_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    accepted_d = accepted_q + 1'b1;
                    if (!enc.ok) begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = TERM;
                    end else if (accepted_q == ACC_W'(NUM_INST - 2)) begin
                        err_d   = 1'b1;
                        state_d = TERM;
                    end
                end
            end
            TERM: begin
                if (term_phase && mem_ready) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wr_fire) begin
            addr_d  = addr_q + WIDTH'(4);
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            accepted_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            accepted_q <= accepted_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign mem_wr_en = wr_en;
    assign mem_addr  = addr_q;
    assign mem_wdata = (wr_en && !fifo_empty) ? WIDTH'(fifo_head) : WIDTH'(NOP_WORD);
    assign busy      = (state_q == LOAD) || (state_q == TERM);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: expected RAM writes are queued when bundles
// are accepted and checked by a write monitor as the DUT emits them.
module tb_inst_mem_loader;

    localparam int WIDTH      = 32;
    localparam int NUM_INST   = 18;
    localparam int FIFO_DEPTH = 2;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        start     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_last   = 1'b0;
    logic [6:0]  opcode    = '0;
    logic [4:0]  rd        = '0;
    logic [4:0]  rs1       = '0;
    logic [4:0]  rs2       = '0;
    logic [2:0]  funct3    = '0;
    logic [6:0]  funct7    = '0;
    logic [31:0] imm       = '0;
    logic        mem_ready = 1'b1;
    logic        in_ready;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] count;

    inst_mem_loader #(
        .WIDTH      (WIDTH),
        .NUM_INST   (NUM_INST),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         mon_e;
    int          total       = 0;
    int          passed      = 0;
    int          writes_seen = 0;
    logic [31:0] exp_addr    = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ADDI with rs1=x0, funct3=0: the I-format layout written out by hand.
    function automatic logic [31:0] model_addi(input logic [4:0] d, input logic [31:0] im);
        return {im[11:0], 5'd0, 3'd0, d, 7'b0010011};
    endfunction

    always @(negedge clk) begin
        if (!rst && mem_wr_en && mem_ready) begin
            writes_seen++;
            if (sb.size() == 0) begin
                total++;
                $error("FAIL spurious_write: observed addr %h data %h expected no write",
                       mem_addr, mem_wdata);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", mem_addr, mon_e.addr);
                chk("wr_data", mem_wdata, mon_e.data);
                $display("write addr=%h data=%h", mem_addr, mem_wdata);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        exp_addr = '0;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im, input logic last,
                        input logic [31:0] exp_word, input logic exp_ok);
        int cyc;
        opcode   = op;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        funct3   = f3;
        funct7   = f7;
        imm      = im;
        in_last  = last;
        in_valid = 1'b1;
        cyc      = 0;
        while (!in_ready && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        if (in_ready) begin
            if (exp_ok) begin
                sb.push_back('{exp_addr, exp_word});
                exp_addr += 4;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("bundle op=%b rd=%0d imm=%0d last=%b expected_word=%h", op, d, im, last, exp_word);
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_wr_en"},    32'(mem_wr_en), 32'd0);
        chk({tag, "_addr"},     mem_addr, 32'd0);
        chk({tag, "_wdata"},    mem_wdata, 32'd0);
        chk({tag, "_busy"},     32'(busy), 32'd0);
        chk({tag, "_done"},     32'(done), 32'd0);
        chk({tag, "_err"},      32'(err), 32'd0);
        chk({tag, "_count"},    count, 32'd0);
    endtask

    initial begin
        int w0;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single ADDI followed by the terminator.
        do_start();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd10, 1'b1, 32'h00A08093, 1'b1);
        sb.push_back('{exp_addr, 32'h0});
        wait_done("t1_done");
        chk("t1_count", count, 32'd2);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_drained", 32'(sb.size()), 32'd0);

        // One bundle of each format.
        do_start();
        send(7'b0110011, 5'd3, 5'd2, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0, 32'h001101B3, 1'b1);
        send(7'b0100011, 5'd0, 5'd0, 5'd10, 3'd2, 7'd0, 32'd132, 1'b0, 32'h08A02223, 1'b1);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd396, 1'b0, 32'h18208663, 1'b1);
        send(7'b0010011, 5'd13, 5'd10, 5'd0, 3'd5, 7'h20, 32'd5, 1'b1, 32'h40555693, 1'b1);
        chk("t2_term_addr", exp_addr, 32'd16);
        sb.push_back('{exp_addr, 32'h0});
        wait_done("t2_done");
        chk("t2_count", count, 32'd5);
        chk("t2_drained", 32'(sb.size()), 32'd0);

        // Back-pressure: RAM stalls while three bundles are offered.
        mem_ready = 1'b0;
        do_start();
        send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, model_addi(5'd5, 32'd1), 1'b1);
        send(7'b0010011, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, model_addi(5'd6, 32'd2), 1'b1);
        opcode   = 7'b0010011;
        rd       = 5'd7;
        imm      = 32'd3;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("t3_stall_in_ready", 32'(in_ready), 32'd0);
            chk("t3_stall_wr_en", 32'(mem_wr_en), 32'd1);
            chk("t3_stall_addr", mem_addr, 32'd0);
            chk("t3_stall_wdata", mem_wdata, model_addi(5'd5, 32'd1));
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        send(7'b0010011, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1, model_addi(5'd7, 32'd3), 1'b1);
        sb.push_back('{exp_addr, 32'h0});
        wait_done("t3_done");
        chk("t3_count", count, 32'd4);
        chk("t3_drained", 32'(sb.size()), 32'd0);

        // Capacity overflow: no in_last within the allowed slots.
        do_start();
        for (int i = 0; i < NUM_INST - 1; i++) begin
            send(7'b0010011, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 3), 1'b0,
                 model_addi(5'(i + 1), 32'(i * 3)), 1'b1);
        end
        chk("t4_term_addr", exp_addr, 32'd68);
        sb.push_back('{exp_addr, 32'h0});
        opcode   = 7'b0010011;
        rd       = 5'd31;
        in_valid = 1'b1;
        chk("t4_18th_refused", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("t4_18th_refused2", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_done("t4_done");
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_count", count, 32'd18);
        chk("t4_drained", 32'(sb.size()), 32'd0);

        // Unsupported opcode is consumed but never written.
        do_start();
        chk("t5_err_cleared", 32'(err), 32'd0);
        w0 = writes_seen;
        send(7'b1111111, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0, 1'b0);
        chk("t5_err_set", 32'(err), 32'd1);
        send(7'b0010011, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd42, 1'b1, model_addi(5'd9, 32'd42), 1'b1);
        sb.push_back('{exp_addr, 32'h0});
        wait_done("t5_done");
        chk("t5_writes", 32'(writes_seen - w0), 32'd2);
        chk("t5_count", count, 32'd2);
        chk("t5_err_sticky", 32'(err), 32'd1);

        // Asynchronous reset in the middle of a stalled load.
        mem_ready = 1'b0;
        do_start();
        send(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0, model_addi(5'd4, 32'd7), 1'b1);
        chk("t6_wr_en_before", 32'(mem_wr_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("t6_async");
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        do_start();
        send(7'b0010011, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd11, 1'b1, model_addi(5'd8, 32'd11), 1'b1);
        sb.push_back('{exp_addr, 32'h0});
        wait_done("t6_done");
        chk("t6_count", count, 32'd2);
        chk("t6_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction ROM/fetch path: accepts decoded instruction fields over a valid/ready stream, encodes them into 32-bit RV32I machine words and writes them sequentially into program RAM.
- Appends the mandatory NO-OP (32'h0) terminator after the last instruction.
- Sits between the test/boot program source and the instruction memory write port.
- Encoding is the exact inverse of the fetch-side field extraction.

Parameters:
- WIDTH, 32, data/address width.
- NUM_INST, 18, program RAM depth in words, including the terminator slot.
- FIFO_DEPTH, 2, entries in the encoded-word buffer; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a load; honoured in IDLE or DONE only
- in_valid  in  1  field bundle valid
- in_ready  out  1  field bundle accepted when in_valid && in_ready
- in_last  in  1  bundle is the final program instruction
- opcode  in  7  instruction opcode
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field
- imm  in  WIDTH  signed immediate; byte offset for S/B formats
- mem_wr_en  out  1  program RAM write strobe
- mem_addr  out  WIDTH  byte address, word-aligned
- mem_wdata  out  WIDTH  encoded word
- mem_ready  in  1  RAM accepts the write this cycle
- busy  out  1  state is LOAD or TERM
- done  out  1  high in DONE
- err  out  1  sticky error; cleared on start
- count  out  WIDTH  words written so far, including the terminator

Behaviour:
- Reset (async): state IDLE, FIFO empty, address counter 0. All outputs 0: in_ready, mem_wr_en, mem_addr, mem_wdata, busy, done, err, count.
- States:
  - IDLE: start -> LOAD.
  - LOAD: accept bundles. The accepted in_last bundle, or capacity reached, -> TERM.
  - TERM: once the FIFO is empty, drive the NO-OP write. When it is accepted by mem_ready -> DONE.
  - DONE: start -> LOAD.
  - On entering LOAD: address, count and err all cleared.
- in_ready = (state == LOAD) && FIFO not full && accepted < NUM_INST-1. One slot is always reserved for the terminator.
- Encode is registered: an accepted bundle is written into the FIFO at the next clock edge. Earliest mem_wr_en is 1 cycle after acceptance.
- Encoding by opcode:
  - 0110011 (R): {funct7, rs2, rs1, funct3, rd, opcode}.
  - 0010011 / 0000011 (I): {imm[11:0], rs1, funct3, rd, opcode}.
    - Exception: opcode 0010011 with funct3 001 or 101 encodes as {funct7, imm[4:0], rs1, funct3, rd, opcode}.
  - 0100011 (S): {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - 1100011 (B): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. imm[0] is ignored.
  - Any other opcode: err set, word dropped (not written), and the handshake still completes.
- Immediate bits outside the format are truncated silently.
- Write port:
  - mem_wr_en = FIFO non-empty in LOAD/TERM, or the terminator phase of TERM.
  - mem_wdata/mem_addr are held stable while mem_wr_en && !mem_ready.
  - On mem_ready: FIFO pops, mem_addr += 4, count += 1.
- Simultaneous push and pop on a full FIFO is permitted. Occupancy is unchanged.
- Capacity overflow: NUM_INST-1 bundles accepted without in_last -> err set, in_ready low, -> TERM. The terminator is written at byte address 4*(NUM_INST-1).
- in_last on the final allowed slot is not an error.
- start while busy is ignored.
- Reset mid-load aborts immediately. RAM contents are then undefined and must be reloaded.

Decomposition:
- Shared package rv_pkg holds:
  - Opcode constants OP_R=7'b0110011, OP_I=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011.
  - NOP_WORD = 32'h0.
  - State enum loader_state_t {IDLE, LOAD, TERM, DONE}.
  - These constants are reused by the fetch/decode block.
- One sub-module: sync_fifo (WIDTH, FIFO_DEPTH), holding encoded words. Encode is a function in rv_pkg.

Test Plan:
- ADDI rd=1, rs1=1, funct3=0, imm=10 with in_last, mem_ready=1 -> 0x00A08093 written at addr 0. Then 0x0 at addr 4; done=1, count=2.
- The following bundles, in order, with mem_ready=1:
  - ADD rd=3, rs1=2, rs2=1 -> 0x001101B3.
  - SW rs2=10, rs1=0, funct3=2, imm=132 -> 0x08A02223.
  - BEQ rs1=1, rs2=2, imm=396 -> 0x18208663.
  - SRAI rd=13, rs1=10, funct3=5, funct7=0x20, imm=5 -> 0x40555693.
  - Then the terminator at addr 16.
- Hold mem_ready=0 for 5 cycles with 3 bundles offered -> at most 2 accepted (FIFO full), in_ready low, mem_addr/mem_wdata stable. Release -> all 3 words written in order at 0, 4, 8.
- 18 bundles without in_last -> 17 accepted, err=1, 0x0 written at addr 68, done=1.
- Bundle with opcode 7'b1111111 -> handshake completes, no RAM write for it, err=1; the next valid bundle is written at the unadvanced address.
- rst asserted asynchronously mid-LOAD with mem_wr_en high -> all outputs 0 immediately, state IDLE. A subsequent start reloads from addr 0.
